// File: rtl/ifft8_seq_if.sv
// Handshake bundle for ifft8_seq: frequency bins in, time samples out.
// The master side drives bins and out_ready; the slave side is the transform block.
interface ifft8_seq_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_re;
    logic [W-1:0] in_im;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [2:0]   out_idx;
    logic         out_last;

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/ifft8_seq.sv
// Sequential 8-point inverse DFT (real part only) on sign-magnitude words.
// Each output sample is accumulated one bin per cycle, then scaled by 1/8 and saturated.
module ifft8_seq #(
    parameter int W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    ifft8_seq_if.slave bus
);
    localparam int AW = W + 4;
    localparam logic [AW-1:0] MAXQ = {5'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

    state_t              state;
    state_t              state_nx;
    logic [2:0]          kcnt;
    logic [2:0]          n;
    logic [3:0]          kidx;
    logic signed [AW-1:0] acc;
    logic                ready_q;
    logic [W-1:0]        out_data_q;
    logic [2:0]          out_idx_q;
    logic                out_last_q;
    logic [W-1:0]        re_mem [8];
    logic [W-1:0]        im_mem [8];

    logic                load_hs;
    logic [2:0]          m;
    logic [W-1:0]        re_sel;
    logic [W-1:0]        im_sel;
    logic signed [AW-1:0] re_full;
    logic signed [AW-1:0] re_half;
    logic signed [AW-1:0] im_full;
    logic signed [AW-1:0] im_half;
    logic signed [AW-1:0] term;
    logic [AW-1:0]       abs_acc;
    logic [AW-1:0]       q;
    logic [W-2:0]        res_mag;
    logic                res_sign;

    // Signed value of a sign-magnitude word, optionally scaled by 181/256 on the magnitude
    function automatic logic signed [AW-1:0] sm_val(input logic [W-1:0] v, input logic half);
        logic [W+6:0]         mag;
        logic signed [AW-1:0] s;
        mag = {8'b0, v[W-2:0]};
        if (half)
            mag = (mag * (W+7)'(181)) >> 8;
        s = AW'(mag);
        return v[W-1] ? -s : s;
    endfunction

    assign load_hs       = (state == LOAD) && ready_q && bus.in_valid;
    assign bus.in_ready  = ready_q;
    assign bus.out_valid = (state == OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

    assign m       = kidx[2:0] * n;
    assign re_sel  = re_mem[kidx[2:0]];
    assign im_sel  = im_mem[kidx[2:0]];
    assign re_full = sm_val(re_sel, 1'b0);
    assign re_half = sm_val(re_sel, 1'b1);
    assign im_full = sm_val(im_sel, 1'b0);
    assign im_half = sm_val(im_sel, 1'b1);

    // Term Xr*cos - Xi*sin for the twiddle angle m*45 degrees
    always_comb begin
        term = '0;
        case (m)
            3'd0: term = re_full;
            3'd1: term = re_half - im_half;
            3'd2: term = -im_full;
            3'd3: term = -re_half - im_half;
            3'd4: term = -re_full;
            3'd5: term = -re_half + im_half;
            3'd6: term = im_full;
            3'd7: term = re_half + im_half;
            default: term = '0;
        endcase
    end

    always_comb begin
        abs_acc  = acc[AW-1] ? -acc : acc;
        q        = abs_acc >> 3;
        res_mag  = (q > MAXQ) ? {(W-1){1'b1}} : q[W-2:0];
        res_sign = acc[AW-1] && (q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= LOAD;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD: if (load_hs && kcnt == 3'd7) state_nx = CALC;
            CALC: if (kidx == 4'd8) state_nx = OUT;
            OUT:  if (bus.out_ready) state_nx = (n == 3'd7) ? LOAD : CALC;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kcnt       <= '0;
            n          <= '0;
            kidx       <= '0;
            acc        <= '0;
            ready_q    <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            ready_q <= (state_nx == LOAD);
            case (state)
                LOAD: begin
                    if (load_hs) begin
                        kcnt <= kcnt + 3'd1;
                        if (kcnt == 3'd7) begin
                            n    <= '0;
                            kidx <= '0;
                            acc  <= '0;
                        end
                    end
                end
                CALC: begin
                    // Ninth cycle latches the scaled result instead of adding a term
                    if (!kidx[3]) begin
                        acc  <= acc + term;
                        kidx <= kidx + 4'd1;
                    end else begin
                        out_data_q <= {res_sign, res_mag};
                        out_idx_q  <= n;
                        out_last_q <= (n == 3'd7);
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_last_q <= 1'b0;
                        kidx       <= '0;
                        acc        <= '0;
                        if (n == 3'd7) begin
                            n    <= '0;
                            kcnt <= '0;
                        end else begin
                            n <= n + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load_hs) begin
            re_mem[kcnt] <= bus.in_re;
            im_mem[kcnt] <= bus.in_im;
        end
    end
endmodule

// File: tb/tb_ifft8_seq.sv
// Self-checking bench for ifft8_seq: directed frames from the requirements plus
// random frames compared against a table-free trigonometric reference model.
module tb_ifft8_seq;
    localparam int  W  = 32;
    localparam real PI = 3.14159265358979;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [W-1:0] frame_re [8];
    logic [W-1:0] frame_im [8];
    logic [W-1:0] got_data [8];
    logic [W-1:0] exp_data [8];
    int           ts [8];

    ifft8_seq_if #(.W(W)) bus ();

    ifft8_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic longint sm_to_int(input logic [W-1:0] v);
        longint mag;
        mag = longint'(v[W-2:0]);
        return v[W-1] ? -mag : mag;
    endfunction

    function automatic logic [W-1:0] enc(input longint v);
        longint mag;
        logic [63:0] bits;
        mag = (v < 0) ? -v : v;
        if (mag > 64'd2147483647) mag = 64'd2147483647;
        bits = mag;
        return {(v < 0), bits[W-2:0]};
    endfunction

    function automatic int factor_code(input real c);
        if (c > 0.9)  return 2;
        if (c < -0.9) return -2;
        if (c > 0.1)  return 1;
        if (c < -0.1) return -1;
        return 0;
    endfunction

    function automatic longint apply_factor(input longint v, input int f);
        longint a;
        longint h;
        a = (v < 0) ? -v : v;
        h = (a * 181) / 256;
        case (f)
            2:  return v;
            -2: return -v;
            1:  return (v < 0) ? -h : h;
            -1: return (v < 0) ? h : -h;
            default: return 0;
        endcase
    endfunction

    function automatic logic [W-1:0] model_sample(input int n);
        longint acc;
        real    th;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            th  = PI / 4.0 * real'((k * n) % 8);
            acc += apply_factor(sm_to_int(frame_re[k]), factor_code($cos(th)))
                 - apply_factor(sm_to_int(frame_im[k]), factor_code($sin(th)));
        end
        return enc(acc / 8);
    endfunction

    function automatic logic [W-1:0] rand_sm();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return {1'b1, {(W-1){1'b0}}};
        if (sel <= 3) return {1'($urandom_range(0, 1)), 31'($urandom_range(0, 5000))};
        return $urandom;
    endfunction

    task automatic clear_frame();
        for (int k = 0; k < 8; k++) begin
            frame_re[k] = '0;
            frame_im[k] = '0;
        end
    endtask

    task automatic apply_stimulus(input int count);
        int wait_cnt;
        for (int k = 0; k < count; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re    = frame_re[k];
            bus.in_im    = frame_im[k];
            wait_cnt     = 0;
            while (bus.in_ready !== 1'b1 && wait_cnt < 100) begin
                @(posedge clk); #1;
                wait_cnt++;
            end
            check_output("in_ready_wait", 64'(bus.in_ready), 64'd1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic collect_frame(input int stall_idx, input int stall_len, input bit garbage);
        int           cnt;
        logic [W-1:0] held;
        for (int s = 0; s < 8; s++) begin
            cnt = 0;
            while (bus.out_valid !== 1'b1 && cnt < 200) begin
                if (garbage) begin
                    bus.in_valid = 1'b1;
                    bus.in_re    = $urandom;
                    bus.in_im    = $urandom;
                end
                @(posedge clk); #1;
                cnt++;
            end
            check_output($sformatf("gap_%0d", s), 64'(cnt), 64'd9);
            check_output($sformatf("out_idx_%0d", s), 64'(bus.out_idx), 64'(s));
            check_output($sformatf("out_last_%0d", s), 64'(bus.out_last), 64'(s == 7));
            check_output($sformatf("in_ready_out_%0d", s), 64'(bus.in_ready), 64'd0);
            if (s == stall_idx) begin
                bus.out_ready = 1'b0;
                held = bus.out_data;
                for (int j = 0; j < stall_len; j++) begin
                    @(posedge clk); #1;
                    check_output("stall_valid", 64'(bus.out_valid), 64'd1);
                    check_output("stall_data", 64'(bus.out_data), 64'(held));
                    check_output("stall_idx", 64'(bus.out_idx), 64'(s));
                    check_output("stall_in_ready", 64'(bus.in_ready), 64'd0);
                end
                bus.out_ready = 1'b1;
            end
            got_data[s] = bus.out_data;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check_output("frame_end_valid", 64'(bus.out_valid), 64'd0);
        check_output("frame_end_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic check_frame(input string tag);
        for (int s = 0; s < 8; s++)
            check_output($sformatf("%s_x%0d", tag, s), 64'(got_data[s]), 64'(exp_data[s]));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check_output({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check_output({tag, "_out_data"}, 64'(bus.out_data), 64'd0);
        check_output({tag, "_out_idx"}, 64'(bus.out_idx), 64'd0);
        check_output({tag, "_out_last"}, 64'(bus.out_last), 64'd0);
    endtask

    initial begin
        longint diff;
        real    sre;
        real    sim;
        int     stall_at;

        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        check_output("in_ready_before_edge", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        check_output("in_ready_after_edge", 64'(bus.in_ready), 64'd1);

        // DC frame
        clear_frame();
        frame_re[0] = enc(800);
        apply_stimulus(8);
        collect_frame(-1, 0, 1'b0);
        for (int s = 0; s < 8; s++) exp_data[s] = enc(100);
        check_frame("dc");

        // Nyquist frame; -100 must be 0x80000064
        clear_frame();
        frame_re[4] = enc(800);
        apply_stimulus(8);
        collect_frame(-1, 0, 1'b0);
        for (int s = 0; s < 8; s++) exp_data[s] = (s % 2 == 0) ? 32'h0000_0064 : 32'h8000_0064;
        check_frame("nyq");

        // Bin-1 cosine
        clear_frame();
        frame_re[1] = enc(400);
        frame_re[7] = enc(400);
        apply_stimulus(8);
        collect_frame(-1, 0, 1'b0);
        exp_data[0] = enc(100);  exp_data[1] = enc(70);   exp_data[2] = enc(0);    exp_data[3] = enc(-70);
        exp_data[4] = enc(-100); exp_data[5] = enc(-70);  exp_data[6] = enc(0);    exp_data[7] = enc(70);
        check_frame("cos1");

        // Backpressure on sample 3
        clear_frame();
        frame_re[0] = enc(800);
        apply_stimulus(8);
        collect_frame(3, 5, 1'b0);
        for (int s = 0; s < 8; s++) exp_data[s] = enc(100);
        check_frame("bp");

        // Reset after four bins, then a clean DC frame
        clear_frame();
        frame_re[0] = enc(800);
        frame_re[1] = enc(12345);
        frame_im[2] = enc(-777);
        apply_stimulus(4);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("midreset_no_output", 64'(bus.out_valid), 64'd0);
        clear_frame();
        frame_re[0] = enc(800);
        apply_stimulus(8);
        collect_frame(-1, 0, 1'b0);
        for (int s = 0; s < 8; s++) exp_data[s] = enc(100);
        check_frame("postreset");

        // Round trip from a known time sequence
        ts = '{240, 260, 0, 220, 0, 300, 400, 0};
        for (int k = 0; k < 8; k++) begin
            sre = 0.0;
            sim = 0.0;
            for (int t = 0; t < 8; t++) begin
                sre += real'(ts[t]) * $cos(2.0 * PI * real'(k * t) / 8.0);
                sim -= real'(ts[t]) * $sin(2.0 * PI * real'(k * t) / 8.0);
            end
            frame_re[k] = enc(longint'(sre));
            frame_im[k] = enc(longint'(sim));
        end
        apply_stimulus(8);
        collect_frame(-1, 0, 1'b0);
        for (int s = 0; s < 8; s++) begin
            diff = sm_to_int(got_data[s]) - longint'(ts[s]);
            checks++;
            assert (diff <= 2 && diff >= -2)
            else begin
                failures++;
                $error("[TB] FAIL roundtrip_x%0d observed=%0d expected=%0d+/-2", s, sm_to_int(got_data[s]), ts[s]);
            end
            exp_data[s] = model_sample(s);
        end
        check_frame("rt_model");

        // Random frames against the reference model, with ignored writes and a stall mixed in
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 8; k++) begin
                frame_re[k] = rand_sm();
                frame_im[k] = rand_sm();
            end
            stall_at = (f == 4) ? int'($urandom_range(0, 7)) : -1;
            apply_stimulus(8);
            collect_frame(stall_at, 3, f == 2);
            for (int s = 0; s < 8; s++) exp_data[s] = model_sample(s);
            check_frame($sformatf("rand%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifft8_seq.md
IFFT8_SEQ -- requirements
Module: ifft8_seq

Interface
REQ-001 SHALL have parameter: W, default 32, sign-magnitude word width (bit W-1 = sign, bits W-2:0 = magnitude).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  frequency bin present on in_re/in_im.
REQ-005 SHALL have port: in_ready  output  1  block accepts a bin this cycle.
REQ-006 SHALL have port: in_re  input  W  real part of bin X[k], sign-magnitude.
REQ-007 SHALL have port: in_im  input  W  imaginary part of bin X[k], sign-magnitude.
REQ-008 SHALL have port: out_valid  output  1  time sample present on out_data.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts the sample this cycle.
REQ-010 SHALL have port: out_data  output  W  time sample x[n], sign-magnitude.
REQ-011 SHALL have port: out_idx  output  3  sample index n of out_data.
REQ-012 SHALL have port: out_last  output  1  high together with out_valid when n = 7.

Function
REQ-013 SHALL compute the real part of the 8-point inverse DFT: x[n] = Re( sum over k=0..7 of X[k]*e^(+j*2*pi*k*n/8) ) / 8.
REQ-014 SHALL implement a three-state FSM: LOAD, CALC, OUT.
REQ-015 In LOAD, in_ready SHALL be 1; each cycle with in_valid=1 stores the bin at address kcnt and increments kcnt; bins arrive in order k = 0..7.
REQ-016 On the handshake with kcnt = 7, the FSM SHALL move to CALC with n = 0 and the accumulator cleared.
REQ-017 In CALC, the block SHALL add exactly one term per cycle for k = 0..7 (8 cycles), then move to OUT.
REQ-018 Each term SHALL be Xr*cos(theta) - Xi*sin(theta) with theta = (k*n mod 8)*45 degrees; factors 0 and +/-1 exact; factors +/-0.7071 realised as sign applied to trunc(|v|*181/256).
REQ-019 The accumulator SHALL be two's complement, at least W+4 bits, with no intermediate overflow for any legal input.
REQ-020 Final value SHALL be accumulator/8 truncated toward zero, converted to sign-magnitude, magnitude saturated to 2^(W-1)-1; zero SHALL be output with sign 0.
REQ-021 Input -0 (sign 1, magnitude 0) SHALL be treated as 0.
REQ-022 In OUT, out_valid SHALL be 1 and out_data/out_idx/out_last SHALL be held stable until out_ready = 1.
REQ-023 On an OUT handshake with n < 7, the FSM SHALL return to CALC with n+1 and the accumulator cleared; with n = 7, it SHALL return to LOAD with kcnt = 0.
REQ-024 out_valid SHALL first rise 9 cycles after the clock edge accepting bin 7; with out_ready held at 1, consecutive samples SHALL be spaced 9 cycles apart.
REQ-025 in_ready SHALL be 0 in CALC and OUT; in_valid in those states SHALL be ignored with no storage change.
REQ-026 out_valid SHALL be 0 in LOAD and CALC.

Reset
REQ-027 While rst_n = 0: state = LOAD, kcnt = 0, n = 0, accumulator = 0, in_ready = 0, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0.
REQ-028 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-029 Reset in any state SHALL discard partially loaded bins and any frame in progress; no output SHALL appear for that frame.

Verification
REQ-030 DC frame: X0 = 800+j0, all other bins 0 -> eight samples, each 100, out_idx 0..7, out_last only on idx 7.
REQ-031 Nyquist frame: X4 = 800, others 0 -> samples 100, -100, 100, -100, ... (-100 encoded as 0x80000064).
REQ-032 Bin-1 cosine: X1 = X7 = 400, others 0 -> samples 100, 70, 0, -70, -100, -70, 0, 70.
REQ-033 Backpressure: out_ready = 0 for 5 cycles on sample 3 -> out_data/out_idx held, no sample skipped or repeated; in_ready stays 0 throughout.
REQ-034 Reset mid-frame: assert rst_n = 0 after 4 bins loaded -> all outputs 0; a subsequent full DC frame (REQ-030) produces the correct result.
REQ-035 Round trip: the spectrum of time samples 240, 260, 0, 220, 0, 300, 400, 0, rounded to integers, is fed in -> outputs within +/-2 of those eight values.
